fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the program counter logic and the synchronous-read instruction memory. It owns the PC, drives the memory word address, tracks the one-cycle memory read latency, and buffers returned instructions in a 2-entry queue toward decode with a valid/ready handshake. It supports stalls, branch/jump redirects with in-flight kill, and an error stop on out-of-range or misaligned PCs.

---
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues memory reads and
// buffers returned instructions in a 2-entry queue toward decode.
module fetch_ctrl #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [1:0]        count;
  logic [31:0]       tl_inst;
  logic [ADDR_W-1:0] tl_pc;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic              pc_bad;
  logic              rd_bad;

  function automatic logic bad(input logic [ADDR_W-1:0] a);
    return ((a >> 2) >= ADDR_W'(MEM_DEPTH)) || (a[1:0] != 2'b00);
  endfunction

  assign pc_bad     = bad(pc);
  assign rd_bad     = bad(redir_pc);
  assign mem_addr   = pc >> 2;
  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign push       = req_q & ~redir_valid;
  // Occupancy after this cycle's pop, counting the in-flight read.
  assign occ        = 3'(count) + 3'(req_q) - 3'(pop);
  assign issue      = (state == RUN) && !pc_bad &&
                      !redir_valid && (occ < 3'd2);

  always_comb begin
    state_nx = state;
    if (redir_valid) begin
      if (rd_bad)
        state_nx = ERR;
      else if (state == ERR)
        state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pc_bad)        state_nx = ERR;
          else if (fetch_en) state_nx = RUN;
        end
        RUN: begin
          if (pc_bad)         state_nx = ERR;
          else if (!fetch_en) state_nx = IDLE;
        end
        default: state_nx = ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nx;
      fetch_err <= (state_nx == ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pc_q     <= '0;
      req_q    <= 1'b0;
      count    <= 2'd0;
      inst_out <= '0;
      inst_pc  <= '0;
      tl_inst  <= '0;
      tl_pc    <= '0;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc_q <= pc;
        pc   <= pc + ADDR_W'(4);
      end
      if (redir_valid) begin
        count <= 2'd0;
        if (!rd_bad)
          pc <= redir_pc;
      end else begin
        unique case (1'b1)
          pop && (count == 2'd2): begin
            inst_out <= tl_inst;
            inst_pc  <= tl_pc;
            if (push) begin
              tl_inst <= mem_data;
              tl_pc   <= pc_q;
              count   <= 2'd2;
            end else begin
              count   <= 2'd1;
            end
          end
          push && ((count == 2'd0) ||
                   ((count == 2'd1) && pop)): begin
            inst_out <= mem_data;
            inst_pc  <= pc_q;
            count    <= 2'd1;
          end
          push && (count == 2'd1) && !pop: begin
            tl_inst <= mem_data;
            tl_pc   <= pc_q;
            count   <= 2'd2;
          end
          pop && !push && (count == 2'd1): begin
            count <= 2'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a synchronous-read memory model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fetch_ctrl;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_out;
  logic [AW-1:0] inst_pc;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          fetch_err;

  logic [31:0] mem [0:1023];
  logic [31:0] pat [0:2];

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.ADDR_W(AW), .RESET_PC('0), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_data <= (mem_addr < 64'd1024) ? mem[mem_addr[9:0]] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 64'(inst_valid), 64'd1);
  endtask

  function automatic logic [31:0] inst_at(logic [63:0] bpc);
    return pat[(bpc >> 2) % 3];
  endfunction

  initial begin
    logic [63:0] exp_pc;
    pat[0] = 32'h015A04B3;
    pat[1] = 32'h015A34B3;
    pat[2] = 32'h015A3CB3;
    for (int i = 0; i < 1024; i++) mem[i] = pat[i % 3];
    mem_data    = '0;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    inst_ready  = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    step();
    step();
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_inst", 64'(inst_out), 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    rst_n = 1'b1;
    step();

    // Stream: first valid 3 cycles after enable
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    step();
    chk("lat1_valid", 64'(inst_valid), 64'd0);
    chk("lat1_addr", mem_addr, 64'd0);
    step();
    chk("lat2_valid", 64'(inst_valid), 64'd0);
    chk("lat2_addr", mem_addr, 64'd1);
    step();
    exp_pc = 64'd0;
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", 64'(inst_valid), 64'd1);
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_inst", 64'(inst_out), 64'(inst_at(exp_pc)));
      exp_pc += 4;
      step();
    end

    // Backpressure: head 0x20 held, issue stops at pc 0x28
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(inst_valid), 64'd1);
      chk("stall_pc", inst_pc, 64'h20);
      chk("stall_inst", 64'(inst_out), 64'(inst_at(64'h20)));
      chk("stall_addr", mem_addr, 64'd10);
      step();
    end
    inst_ready = 1'b1;
    exp_pc = 64'h20;
    for (int i = 0; i < 6; i++) begin
      chk("resume_valid", 64'(inst_valid), 64'd1);
      chk("resume_pc", inst_pc, exp_pc);
      exp_pc += 4;
      step();
    end

    // Redirect with a full queue
    inst_ready = 1'b0;
    step();
    redir_valid = 1'b1;
    redir_pc    = 64'h40;
    step();
    redir_valid = 1'b0;
    inst_ready  = 1'b1;
    chk("redir_flush", 64'(inst_valid), 64'd0);
    chk("redir_addr", mem_addr, 64'h10);
    step();
    chk("redir_gap", 64'(inst_valid), 64'd0);
    step();
    exp_pc = 64'h40;
    for (int i = 0; i < 4; i++) begin
      chk("redir_valid", 64'(inst_valid), 64'd1);
      chk("redir_pc", inst_pc, exp_pc);
      exp_pc += 4;
      step();
    end

    // Redirect together with a pop of head 0x50
    chk("rpop_head", inst_pc, 64'h50);
    redir_valid = 1'b1;
    redir_pc    = 64'h100;
    step();
    redir_valid = 1'b0;
    chk("rpop_flush", 64'(inst_valid), 64'd0);
    chk("rpop_addr", mem_addr, 64'h40);
    step();
    chk("rpop_gap", 64'(inst_valid), 64'd0);
    step();
    chk("rpop_valid", 64'(inst_valid), 64'd1);
    chk("rpop_pc0", inst_pc, 64'h100);
    chk("rpop_inst0", 64'(inst_out), 64'(inst_at(64'h100)));
    step();
    chk("rpop_pc1", inst_pc, 64'h104);
    step();

    // Out-of-range redirect target
    redir_valid = 1'b1;
    redir_pc    = 64'h1000;
    step();
    redir_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("range_err", 64'(fetch_err), 64'd1);
      chk("range_noissue", 64'(inst_valid), 64'd0);
      step();
    end
    redir_valid = 1'b1;
    redir_pc    = 64'h10;
    step();
    redir_valid = 1'b0;
    chk("recover_err", 64'(fetch_err), 64'd0);
    chk("recover_addr", mem_addr, 64'h4);
    wait_valid("recover_wait");
    chk("recover_pc", inst_pc, 64'h10);
    chk("recover_inst", 64'(inst_out), 64'(inst_at(64'h10)));
    step();
    chk("recover_pc1", inst_pc, 64'h14);

    // Misaligned redirect target
    redir_valid = 1'b1;
    redir_pc    = 64'h6;
    step();
    redir_valid = 1'b0;
    chk("align_err", 64'(fetch_err), 64'd1);
    chk("align_valid", 64'(inst_valid), 64'd0);
    redir_valid = 1'b1;
    redir_pc    = 64'h20;
    step();
    redir_valid = 1'b0;
    chk("align_clr", 64'(fetch_err), 64'd0);
    wait_valid("align_wait");
    chk("align_pc", inst_pc, 64'h20);

    // fetch_en drop: outstanding fetches drain, then resume
    fetch_en = 1'b0;
    exp_pc   = 64'h20;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid === 1'b1) begin
        chk("drain_pc", inst_pc, exp_pc);
        exp_pc += 4;
      end
      step();
    end
    chk("drain_end", exp_pc, 64'h2C);
    chk("drain_idle", 64'(inst_valid), 64'd0);
    fetch_en = 1'b1;
    wait_valid("reen_wait");
    chk("reen_pc", inst_pc, 64'h2C);
    step();
    step();

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(inst_valid), 64'd0);
    chk("arst_inst", 64'(inst_out), 64'd0);
    chk("arst_pc", inst_pc, 64'd0);
    chk("arst_addr", mem_addr, 64'd0);
    chk("arst_err", 64'(fetch_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
